// File: rtl/loader_pkg.sv
// Shared definitions for the boot/program loader: command and FSM encodings,
// header field positions and default memory geometry.
package loader_pkg;

  typedef enum logic [1:0] {
    CMD_LOAD_IMEM = 2'b00,
    CMD_LOAD_DMEM = 2'b01,
    CMD_RUN       = 2'b10,
    CMD_HALT      = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_HDR     = 2'b00,
    ST_PAYLOAD = 2'b01,
    ST_WRITE   = 2'b10
  } state_e;

  localparam int unsigned HDR_CMD_LSB  = 30;
  localparam int unsigned HDR_BASE_LSB = 16;
  localparam int unsigned HDR_CNT_LSB  = 0;
  localparam int unsigned HDR_CNT_W    = 16;

  localparam int unsigned DEF_IMEM_DEPTH = 256;
  localparam int unsigned DEF_DMEM_DEPTH = 1024;
  localparam int unsigned DEF_ADDR_W     = 14;

  function automatic cmd_e hdr_cmd(input logic [31:0] w);
    return cmd_e'(w[HDR_CMD_LSB +: 2]);
  endfunction

  function automatic logic [HDR_CNT_W-1:0] hdr_count(input logic [31:0] w);
    return w[HDR_CNT_LSB +: HDR_CNT_W];
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Little-endian byte-to-word packer. word_valid_o is combinational so the
// consumer can act on the same edge that accepts the fourth byte.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        accept_en_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] bytes_q, bytes_d;
  logic        accept;

  assign accept       = byte_valid_i && accept_en_i;
  assign word_o       = {byte_i, bytes_q};
  assign word_valid_o = accept && (cnt_q == 2'd3);

  always_comb begin
    cnt_d   = cnt_q;
    bytes_d = bytes_q;
    if (accept) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    bytes_d[7:0]   = byte_i;
        2'd1:    bytes_d[15:8]  = byte_i;
        2'd2:    bytes_d[23:16] = byte_i;
        default: bytes_d        = bytes_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      bytes_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      bytes_q <= bytes_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses header/payload words from a byte stream, writes them into
// instruction or data memory while the CPU is held in reset, then releases it.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = DEF_IMEM_DEPTH,
  parameter int unsigned DMEM_DEPTH = DEF_DMEM_DEPTH,
  parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        imem_we_o,
  output logic [7:0]  imem_addr_o,
  output logic        dmem_we_o,
  output logic [9:0]  dmem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        cpu_run_o,
  output logic        start_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned SUM_W = ((ADDR_W > HDR_CNT_W) ? ADDR_W : HDR_CNT_W) + 1;

  state_e                state_q;
  logic                  rx_ready_q;
  logic                  imem_we_q, dmem_we_q;
  logic [7:0]            imem_addr_q;
  logic [9:0]            dmem_addr_q;
  logic [31:0]           wdata_q;
  logic                  cpu_run_q, start_q, err_q, busy_q;
  logic                  is_dmem_q, discard_q, last_q;
  logic [ADDR_W-1:0]     base_q;
  logic [HDR_CNT_W-1:0]  cnt_q, idx_q;

  logic [31:0]           word;
  logic                  word_valid;
  logic [SUM_W-1:0]      waddr;
  logic [HDR_CNT_W:0]    idx_next;
  logic                  in_bounds;

  byte_assembler u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byte_i       (rx_data_i),
    .byte_valid_i (rx_valid_i),
    .accept_en_i  (rx_ready_q),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // Full-width address so the bounds check sees overflow before truncation.
  assign waddr     = SUM_W'(base_q) + SUM_W'(idx_q);
  assign idx_next  = {1'b0, idx_q} + 1'b1;
  assign in_bounds = is_dmem_q ? (waddr < SUM_W'(DMEM_DEPTH))
                               : (waddr < SUM_W'(IMEM_DEPTH));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_HDR;
      rx_ready_q  <= 1'b0;
      imem_we_q   <= 1'b0;
      dmem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      dmem_addr_q <= '0;
      wdata_q     <= '0;
      cpu_run_q   <= 1'b0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      is_dmem_q   <= 1'b0;
      discard_q   <= 1'b0;
      last_q      <= 1'b0;
      base_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
    end else begin
      imem_we_q <= 1'b0;
      dmem_we_q <= 1'b0;
      case (state_q)
        ST_HDR: begin
          rx_ready_q <= 1'b1;
          if (word_valid) begin
            case (hdr_cmd(word))
              CMD_LOAD_IMEM, CMD_LOAD_DMEM: begin
                if (hdr_count(word) != '0) begin
                  is_dmem_q <= (hdr_cmd(word) == CMD_LOAD_DMEM);
                  base_q    <= word[HDR_BASE_LSB +: ADDR_W];
                  cnt_q     <= hdr_count(word);
                  idx_q     <= '0;
                  // A load while the CPU runs is framed but never written.
                  discard_q <= cpu_run_q;
                  if (cpu_run_q) err_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= ST_PAYLOAD;
                end
              end
              CMD_RUN: begin
                cpu_run_q <= 1'b1;
                start_q   <= 1'b1;
              end
              default: begin
                cpu_run_q <= 1'b0;
                start_q   <= 1'b0;
              end
            endcase
          end
        end
        ST_PAYLOAD: begin
          if (word_valid) begin
            rx_ready_q <= 1'b0;
            state_q    <= ST_WRITE;
            if (!in_bounds) begin
              err_q <= 1'b1;
            end else if (!discard_q) begin
              wdata_q <= word;
              if (is_dmem_q) begin
                dmem_we_q   <= 1'b1;
                dmem_addr_q <= waddr[9:0];
              end else begin
                imem_we_q   <= 1'b1;
                imem_addr_q <= waddr[7:0];
              end
            end
            idx_q  <= idx_next[HDR_CNT_W-1:0];
            last_q <= (idx_next == {1'b0, cnt_q});
          end else begin
            rx_ready_q <= 1'b1;
          end
        end
        ST_WRITE: begin
          rx_ready_q <= 1'b1;
          if (last_q) begin
            state_q <= ST_HDR;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_PAYLOAD;
          end
        end
        default: state_q <= ST_HDR;
      endcase
    end
  end

  assign rx_ready_o  = rx_ready_q;
  assign imem_we_o   = imem_we_q;
  assign imem_addr_o = imem_addr_q;
  assign dmem_we_o   = dmem_we_q;
  assign dmem_addr_o = dmem_addr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_run_o   = cpu_run_q;
  assign start_o     = start_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a word-level stream model predicts every
// memory write and the run/error flags; a monitor checks each strobe.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        imem_we_o;
  logic [7:0]  imem_addr_o;
  logic        dmem_we_o;
  logic [9:0]  dmem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        cpu_run_o;
  logic        start_o;
  logic        err_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int n_imem_wr = 0;
  bit chk_ready_en = 0;

  typedef struct {
    bit          is_d;
    int unsigned addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  // Reference model: interprets the stream word by word.
  int unsigned m_rem, m_base, m_idx;
  bit          m_isd, m_disc, m_run, m_err;

  always #5 clk = ~clk;

  program_loader #(.IMEM_DEPTH(256), .DMEM_DEPTH(1024), .ADDR_W(14)) dut (
    .clk_i(clk), .rst_i(rst_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o), .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .mem_wdata_o(mem_wdata_o),
    .cpu_run_o(cpu_run_o), .start_o(start_o), .err_o(err_o), .busy_o(busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] hdr(input int unsigned cmd, input int unsigned base,
                                      input int unsigned n);
    return (32'(cmd) << 30) | ((32'(base) & 32'h3fff) << 16) | (32'(n) & 32'hffff);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_rem = 0; m_run = 0; m_err = 0; m_disc = 0;
  endfunction

  function automatic void model_word(input logic [31:0] w);
    int unsigned a, depth;
    wr_t e;
    if (m_rem == 0) begin
      case (w[31:30])
        2'b00, 2'b01: if (w[15:0] != 0) begin
          m_rem  = w[15:0];
          m_isd  = w[30];
          m_base = w[29:16];
          m_idx  = 0;
          m_disc = m_run;
          if (m_run) m_err = 1;
        end
        2'b10: m_run = 1;
        default: m_run = 0;
      endcase
    end else begin
      a = m_base + m_idx;
      depth = m_isd ? 1024 : 256;
      if (a >= depth) m_err = 1;
      else if (!m_disc) begin
        e.is_d = m_isd; e.addr = a; e.data = w;
        exp_q.push_back(e);
      end
      m_idx++;
      m_rem--;
    end
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    bit acc;
    int n;
    repeat ($urandom_range(0, maxgap)) @(negedge clk);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    acc = 0;
    for (n = 0; n < 30 && !acc; n++) begin
      acc = rx_ready_o;
      @(negedge clk);
    end
    if (!acc) begin
      errors++;
      $display("FAIL byte_accept_timeout: byte 0x%02h not accepted within 30 cycles", b);
    end
    rx_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    model_word(w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], maxgap);
  endtask

  task automatic drain(input string name);
    repeat (4) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready_o), 0);
    check({tag, "_cpu_run"},  32'(cpu_run_o), 0);
    check({tag, "_start"},    32'(start_o), 0);
    check({tag, "_err"},      32'(err_o), 0);
    check({tag, "_busy"},     32'(busy_o), 0);
    check({tag, "_strobes"},  {30'd0, imem_we_o, dmem_we_o}, 0);
    check({tag, "_wdata"},    mem_wdata_o, 0);
  endtask

  // Monitor: every strobe must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (imem_we_o && dmem_we_o) begin
        errors++;
        $display("FAIL dual_strobe: both memory strobes high");
      end
      if (imem_we_o || dmem_we_o) begin
        wr_t e;
        if (imem_we_o) n_imem_wr++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: imem_we=%0d dmem_we=%0d with nothing expected",
                   imem_we_o, dmem_we_o);
        end else begin
          e = exp_q.pop_front();
          if (dmem_we_o !== e.is_d ||
              (e.is_d ? (32'(dmem_addr_o) !== e.addr) : (32'(imem_addr_o) !== e.addr)) ||
              mem_wdata_o !== e.data) begin
            errors++;
            $display("FAIL write: got dmem=%0d iaddr=%0d daddr=%0d data=0x%08h expected dmem=%0d addr=%0d data=0x%08h",
                     dmem_we_o, imem_addr_o, dmem_addr_o, mem_wdata_o, e.is_d, e.addr, e.data);
          end
        end
        checks++;
        if (rx_ready_o) begin
          errors++;
          $display("FAIL ready_in_write: rx_ready_o=1 during strobe, expected 0");
        end
      end else if (chk_ready_en) begin
        checks++;
        if (!rx_ready_o) begin
          errors++;
          $display("FAIL ready_idle: rx_ready_o=0 outside a write cycle, expected 1");
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int base_wr;
    rst_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_i = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(rx_ready_o), 1);

    // Two-word instruction load.
    send_word(hdr(0, 0, 2), 0);
    send_word(32'h00500093, 0);
    send_word(32'h00000013, 0);
    @(negedge clk);
    check("t1_busy_done", 32'(busy_o), 0);
    check("t1_cpu_run", 32'(cpu_run_o), 0);
    drain("t1_drain");

    // Out-of-bounds second word, then a header parsed normally.
    send_word(hdr(0, 255, 2), 1);
    send_word($urandom, 1);
    send_word($urandom, 1);
    drain("t3_drain");
    check("t3_err", 32'(err_o), 1);
    send_word(hdr(1, 10, 1), 1);
    send_word($urandom, 1);
    drain("t3_next_hdr");

    // Data load then RUN.
    send_word(hdr(1, 3, 1), 0);
    send_word(32'h0000002A, 0);
    send_word(32'h80000000, 0);
    check("t2_cpu_run", 32'(cpu_run_o), 1);
    check("t2_start", 32'(start_o), 1);
    drain("t2_drain");

    // Load while running is consumed without writes; then HALT.
    send_word(hdr(1, 4, 1), 0);
    send_word($urandom, 0);
    drain("t4_drain");
    check("t4_cpu_run_kept", 32'(cpu_run_o), 1);
    check("t4_err", 32'(err_o), 1);
    send_word(32'hC0000000, 0);
    check("t4_halt_run", 32'(cpu_run_o), 0);
    check("t4_halt_start", 32'(start_o), 0);

    // Reset in the middle of a payload word.
    send_word(hdr(1, 7, 1), 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst_i = 1'b1;
    model_reset();
    @(negedge clk);
    check_all_zero("midreset");
    rst_i = 1'b0;
    @(negedge clk);
    w = $urandom;
    send_word(hdr(1, 5, 1), 0);
    send_word(w, 0);
    drain("t5_fresh_load");
    check("t5_err", 32'(err_o), 0);

    // Sixteen-word load with random valid gaps.
    base_wr = n_imem_wr;
    chk_ready_en = 1;
    send_word(hdr(0, 0, 16), 3);
    for (int i = 0; i < 16; i++) send_word($urandom, 3);
    repeat (2) @(negedge clk);
    chk_ready_en = 0;
    drain("t6_drain");
    check("t6_strobes", 32'(n_imem_wr - base_wr), 16);

    // Random mixed loads including zero-length and edge bases.
    for (int t = 0; t < 6; t++) begin
      int unsigned n, b;
      bit d;
      d = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 3);
      b = d ? $urandom_range(1020, 1023) : $urandom_range(252, 255);
      send_word(hdr(32'(d), b, n), 2);
      for (int k = 0; k < int'(n); k++) send_word($urandom, 2);
    end
    drain("rand_drain");
    check("final_err", 32'(err_o), 32'(m_err));
    check("final_run", 32'(cpu_run_o), 32'(m_run));
    check("final_busy", 32'(busy_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
